gpio_irq: RTL and testbench

- Parametrised general-purpose I/O block on a 32-bit Wishbone classic slave port.
- Width is configurable; per-bit direction; atomic set/clear of outputs.
- Inputs pass through a configurable synchroniser, feed rising/falling edge detection, and drive a sticky interrupt status with a single level interrupt output to the system interrupt controller.
- Sits on the peripheral bus as the successor to the fixed 8-bit GPIO.

---
 rtl/gpio_irq.sv | 166 ++++++++++++++++
 tb/tb_gpio_irq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq.sv
// gpio_irq: WIDTH-line GPIO with per-bit direction, atomic set/clear,
// synchronised inputs, rising/falling edge detection and a sticky
// interrupt status. Slave port is Wishbone classic with a registered
// acknowledge and a minimum spacing of two cycles per access.
module gpio_irq #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [2:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic             irq_o
);

  // Register map, indexed by the word address.
  typedef enum logic [2:0] {
    ADR_DATA     = 3'd0,
    ADR_DIR      = 3'd1,
    ADR_SET      = 3'd2,
    ADR_CLR      = 3'd3,
    ADR_RISE_EN  = 3'd4,
    ADR_FALL_EN  = 3'd5,
    ADR_IRQ_STAT = 3'd6,
    ADR_RSVD     = 3'd7
  } reg_adr_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] sync_p;
  logic [WIDTH-1:0] data_rd;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_stat;
  logic [WIDTH-1:0] wr_d;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_data;
  logic             acc;
  logic             wr_acc;
  logic             unused_bus_bits;

  // Burst hints and data bits above WIDTH carry no meaning here.
  assign unused_bus_bits = ^{wb_cti_i, wb_bte_i, wb_dat_i};

  assign acc    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_acc = acc & wb_we_i;
  assign wr_d   = wb_dat_i[WIDTH-1:0];

  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  // Input synchroniser: gpio_i shifts through SYNC_STAGES flops to give s.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift.
  // NOTE: the chain is a handful of flops, not a memory, so it takes the
  // reset like any other register and starts from a known all-zero state.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // A DATA read returns the value s takes on the acknowledging edge, i.e.
  // the input to the last synchroniser stage; wb_dat_o acts as that stage.
  assign data_rd = sync_q[SYNC_STAGES-2];

  // Edge-history register: previous cycle's synchronised value.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      sync_p <= '0;
    end else begin
      sync_p <= sync_s;
    end
  end

  assign rise = sync_s & ~sync_p;
  assign fall = ~sync_s & sync_p;

  // Output, direction and enable registers, written on the acknowledging edge.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      gpio_o     <= '0;
      gpio_dir_o <= '0;
      rise_en    <= '0;
      fall_en    <= '0;
    end else if (wr_acc) begin
      case (wb_adr_i)
        ADR_DATA:    gpio_o     <= wr_d;
        ADR_DIR:     gpio_dir_o <= wr_d;
        ADR_SET:     gpio_o     <= gpio_o | wr_d;
        ADR_CLR:     gpio_o     <= gpio_o & ~wr_d;
        ADR_RISE_EN: rise_en    <= wr_d;
        ADR_FALL_EN: fall_en    <= wr_d;
        default:     ;
      endcase
    end
  end

  assign w1c = (wr_acc && (wb_adr_i == ADR_IRQ_STAT)) ? wr_d : '0;

  // Sticky status: clear-by-write first, then new edges OR in, so an edge
  // landing on the same cycle as its clear keeps the bit set.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      irq_stat <= '0;
    end else begin
      irq_stat <= (irq_stat & ~w1c) | (rise & rise_en) | (fall & fall_en);
    end
  end

  assign irq_o = |irq_stat;

  // Read multiplexer over pre-edge register values; unused bits read 0.
  // NOTE: rd_data gets a full default before the case so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      ADR_DATA:     rd_data[WIDTH-1:0] = data_rd;
      ADR_DIR:      rd_data[WIDTH-1:0] = gpio_dir_o;
      ADR_RISE_EN:  rd_data[WIDTH-1:0] = rise_en;
      ADR_FALL_EN:  rd_data[WIDTH-1:0] = fall_en;
      ADR_IRQ_STAT: rd_data[WIDTH-1:0] = irq_stat;
      ADR_SET, ADR_CLR, ADR_RSVD: rd_data = '0;
      default:      rd_data = '0;
    endcase
  end

  // Bus handshake: single-cycle ack one edge after the strobe; read data
  // is captured on that same edge and held otherwise.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= acc;
      if (acc) begin
        wb_dat_o <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed scenarios with literal expectations followed by a
// randomized bus/pin phase; a behavioural model tracks the block and a
// compare process checks every output on each falling edge.
module tb_gpio_irq;

  localparam int W = 8;
  localparam int S = 2;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [2:0]    wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;
  logic [W-1:0]  gpio_i;
  logic [W-1:0]  gpio_o;
  logic [W-1:0]  gpio_dir_o;
  logic          irq_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 wb_clk = ~wb_clk;

  gpio_irq #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .wb_clk     (wb_clk),
    .wb_rst     (wb_rst),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_we_i    (wb_we_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_cti_i   (wb_cti_i),
    .wb_bte_i   (wb_bte_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_rty_o   (wb_rty_o),
    .gpio_i     (gpio_i),
    .gpio_o     (gpio_o),
    .gpio_dir_o (gpio_dir_o),
    .irq_o      (irq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[k] is the pin value sampled k+1 edges ago (before this edge's push).
  // s seen by the status logic lags the pins by S edges, p by S+1 edges.
  logic [W-1:0] hist [$];
  logic [W-1:0] m_out, m_dir, m_ren, m_fen, m_stat;
  logic         m_ack;
  logic [31:0]  m_dat;

  always @(posedge wb_clk) begin
    logic [W-1:0] s_v, p_v, rise_v, fall_v, d_v, w1c_v, stat_n;
    logic         acc_v;
    if (wb_rst) begin
      m_out = '0; m_dir = '0; m_ren = '0; m_fen = '0; m_stat = '0;
      m_ack = 1'b0; m_dat = '0;
      hist = {};
      repeat (S + 1) hist.push_back('0);
    end else begin
      s_v    = hist[S-1];
      p_v    = hist[S];
      rise_v = s_v & ~p_v;
      fall_v = ~s_v & p_v;
      d_v    = wb_dat_i[W-1:0];
      acc_v  = wb_cyc_i && wb_stb_i && !m_ack;
      w1c_v  = (acc_v && wb_we_i && wb_adr_i == 3'd6) ? d_v : '0;
      stat_n = (m_stat & ~w1c_v) | (rise_v & m_ren) | (fall_v & m_fen);
      if (acc_v) begin
        case (wb_adr_i)
          3'd0:    m_dat = 32'(hist[S-2]);
          3'd1:    m_dat = 32'(m_dir);
          3'd4:    m_dat = 32'(m_ren);
          3'd5:    m_dat = 32'(m_fen);
          3'd6:    m_dat = 32'(m_stat);
          default: m_dat = 32'h0;
        endcase
        if (wb_we_i) begin
          case (wb_adr_i)
            3'd0:    m_out = d_v;
            3'd1:    m_dir = d_v;
            3'd2:    m_out = m_out | d_v;
            3'd3:    m_out = m_out & ~d_v;
            3'd4:    m_ren = d_v;
            3'd5:    m_fen = d_v;
            default: ;
          endcase
        end
      end
      m_ack  = acc_v;
      m_stat = stat_n;
      hist.push_front(gpio_i);
      void'(hist.pop_back());
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge wb_clk) begin
    if (cmp_en) begin
      check("ack",      32'(wb_ack_o),   32'(m_ack));
      check("dat_o",    wb_dat_o,        m_dat);
      check("gpio_o",   32'(gpio_o),     32'(m_out));
      check("gpio_dir", 32'(gpio_dir_o), 32'(m_dir));
      check("irq_o",    32'(irq_o),      32'(m_stat != '0));
      check("err_o",    32'(wb_err_o),   32'h0);
      check("rty_o",    32'(wb_rty_o),   32'h0);
    end
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic bus(input bit we, input logic [2:0] adr, input logic [31:0] dat,
                     output logic [31:0] rdata);
    int n;
    n = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;
    do begin
      tick();
      n++;
    end while (!wb_ack_o && n < 8);
    check("ack_latency", n, 1);
    rdata = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tick();
    check("ack_single_cycle", 32'(wb_ack_o), 32'h0);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
    logic [31:0] r;
    bus(1'b1, adr, dat, r);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, adr, 32'h0, r);
    check(name, r, exp);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r;
    wb_rst = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = '0; wb_bte_i = '0;
    gpio_i = '0;

    // Two reset edges.
    tick();
    cmp_en = 1'b1;
    tick();
    wb_rst = 1'b0;

    // Reset defaults.
    check("rst_gpio_o", 32'(gpio_o), 32'h0);
    check("rst_dir",    32'(gpio_dir_o), 32'h0);
    check("rst_irq",    32'(irq_o), 32'h0);
    for (int a = 0; a < 8; a++) begin
      rd_chk($sformatf("rst_read_%0d", a), 3'(a), 32'h0);
    end

    // Set / clear.
    wr(3'd0, 32'h0000_00A5);
    check("data_wr", 32'(gpio_o), 32'hA5);
    wr(3'd2, 32'h0000_000F);
    check("set_wr", 32'(gpio_o), 32'hAF);
    wr(3'd3, 32'h0000_0081);
    check("clr_wr", 32'(gpio_o), 32'h2E);
    rd_chk("read_set", 3'd2, 32'h0);
    rd_chk("read_clr", 3'd3, 32'h0);
    wr(3'd1, 32'hFFFF_FFFF);
    rd_chk("read_dir_width", 3'd1, 32'h0000_00FF);
    wr(3'd7, 32'hFFFF_FFFF);
    rd_chk("read_rsvd", 3'd7, 32'h0);

    // Input latency: change just after edge N.
    repeat (4) tick();
    gpio_i = 8'h3C;
    rd_chk("latency_n1", 3'd0, 32'h0);        // acked on N+1
    gpio_i = 8'h00;
    repeat (4) tick();
    gpio_i = 8'h3C;
    tick();
    rd_chk("latency_n2", 3'd0, 32'h3C);       // acked on N+2
    gpio_i = 8'h00;
    repeat (4) tick();

    // Rising interrupt on bit 0.
    wr(3'd4, 32'h1);
    wr(3'd6, 32'hFF);
    gpio_i = 8'h01;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("rise_irq_edge%0d", k), 32'(irq_o), (k == 3) ? 32'h1 : 32'h0);
    end
    rd_chk("rise_stat", 3'd6, 32'h01);
    gpio_i = 8'h00;
    repeat (5) tick();
    rd_chk("rise_stat_after_fall", 3'd6, 32'h01);
    wr(3'd6, 32'h1);
    check("rise_cleared_irq", 32'(irq_o), 32'h0);

    // Falling interrupt, bit 2 toggles but is not enabled.
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h2);
    wr(3'd6, 32'hFF);
    gpio_i = 8'h06;
    repeat (5) tick();
    check("fall_no_irq_on_rise", 32'(irq_o), 32'h0);
    gpio_i = 8'h00;
    repeat (5) tick();
    rd_chk("fall_stat", 3'd6, 32'h02);

    // Enabling late does not set status for an old edge.
    wr(3'd6, 32'hFF);
    wr(3'd5, 32'h0);
    gpio_i = 8'h10;
    repeat (5) tick();
    wr(3'd4, 32'h10);
    repeat (3) tick();
    rd_chk("no_retro_set", 3'd6, 32'h0);
    gpio_i = 8'h00;
    repeat (4) tick();

    // Set wins over a simultaneous clear.
    wr(3'd4, 32'h1);
    wr(3'd6, 32'hFF);
    gpio_i = 8'h01;                           // after edge N
    tick();                                   // N+1
    tick();                                   // N+2
    wr(3'd6, 32'h1);                          // acked on N+3, rise[0] that edge
    check("set_over_clear_irq", 32'(irq_o), 32'h1);
    rd_chk("set_over_clear_stat", 3'd6, 32'h01);
    wr(3'd6, 32'h1);
    rd_chk("set_over_clear_later", 3'd6, 32'h0);

    // Reset on the edge that would acknowledge a pending write.
    wr(3'd0, 32'h5A);
    wr(3'd1, 32'hF0);
    wr(3'd5, 32'hFF);
    gpio_i = 8'h01;
    repeat (4) tick();
    gpio_i = 8'h00;
    repeat (4) tick();
    check("pre_rst_irq", 32'(irq_o), 32'h1);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 3'd0; wb_dat_i = 32'h11;
    wb_rst = 1'b1;
    tick();
    check("rst_mid_ack",    32'(wb_ack_o),   32'h0);
    check("rst_mid_gpio_o", 32'(gpio_o),     32'h0);
    check("rst_mid_dir",    32'(gpio_dir_o), 32'h0);
    check("rst_mid_irq",    32'(irq_o),      32'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_rst = 1'b0;
    tick();
    rd_chk("rst_mid_rise_en", 3'd4, 32'h0);
    rd_chk("rst_mid_fall_en", 3'd5, 32'h0);
    rd_chk("rst_mid_stat",    3'd6, 32'h0);

    // Randomized phase: pin activity, idle cycles and random accesses.
    for (int t = 0; t < 400; t++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int c = 0; c < idle; c++) begin
        wb_cyc_i = 1'($urandom_range(0, 1));
        wb_adr_i = 3'($urandom_range(0, 7));
        gpio_i   = gpio_i ^ W'($urandom & $urandom);
        tick();
      end
      wb_cyc_i = 1'b0;
      if (($urandom & 3) == 0) gpio_i = gpio_i ^ W'($urandom & $urandom);
      bus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, r);
    end

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
